// File: rtl/arith_seq_ctrl_pkg.sv
// Shared definitions for the arithmetic sequencing controller: op modes,
// FSM state encoding and the FP16 datapath width.
package arith_seq_ctrl_pkg;

    localparam int FP16_W = 16;

    localparam logic [1:0] MODE_EXP  = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_GELU = 2'd2;
    localparam logic [1:0] MODE_AGG  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXP,
        ST_EXP_DRAIN,
        ST_NORM,
        ST_NORM_DRAIN,
        ST_AGG,
        ST_DONE
    } state_t;

    // A token needs at least one expert and no more than the buffer holds.
    function automatic logic k_in_range(input logic [3:0] k, input int max_k);
        return (k != 4'd0) && (int'({28'd0, k}) <= max_k);
    endfunction

endpackage

// File: rtl/seq_score_buf.sv
// Gating-score storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; every entry is written before it is read.
module seq_score_buf
    import arith_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [FP16_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [FP16_W-1:0] rd_data
);

    logic [FP16_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/arith_seq_ctrl.sv
// Per-token sequencer for the softmax/aggregate arithmetic pipeline:
// load k scores, issue exp+sum, drain, issue divides, drain, pass k aggregates.
//
// state         | meaning
// ST_IDLE       | waiting for start; standalone GeLU requests pass through
// ST_LOAD       | accepting k gating scores into the buffer
// ST_EXP        | issuing k exp+sum ops from the buffer
// ST_EXP_DRAIN  | DRAIN_CYC idle cycles so the sum is final
// ST_NORM       | issuing k divide ops from the buffer
// ST_NORM_DRAIN | DRAIN_CYC idle cycles so the last divide retires
// ST_AGG        | passing k expert outputs/psums through to the pipeline
// ST_DONE       | one-cycle completion pulse
module arith_seq_ctrl
    import arith_seq_ctrl_pkg::*;
#(
    parameter int MAX_K     = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        cfg_k,
    input  logic              sc_valid,
    output logic              sc_ready,
    input  logic [FP16_W-1:0] sc_data,
    input  logic              agg_valid,
    output logic              agg_ready,
    input  logic [FP16_W-1:0] agg_data,
    input  logic [FP16_W-1:0] agg_psum,
    input  logic              gelu_valid,
    output logic              gelu_ready,
    input  logic [FP16_W-1:0] gelu_data,
    output logic              ap_valid,
    output logic [1:0]        ap_mode,
    output logic [FP16_W-1:0] ap_data,
    output logic [FP16_W-1:0] ap_psum,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CW = $clog2(MAX_K) + 1;
    localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     k_q, k_d;
    logic              err_q, err_d;
    logic [CW-1:0]     k_last;
    logic              last_op;
    logic              drain_end;
    logic              sc_wr;
    logic [FP16_W-1:0] buf_rdata;

    assign k_last    = k_q - CW'(1);
    assign last_op   = (cnt_q == k_last);
    // The drain count shares the op counter, so DRAIN_CYC must fit in CW bits.
    assign drain_end = (cnt_q == CW'(DRAIN_CYC - 1));
    assign sc_wr     = (state_q == ST_LOAD) && sc_valid;

    seq_score_buf #(
        .DEPTH (MAX_K),
        .AW    (AW)
    ) u_score_buf (
        .clk     (clk),
        .wr_en   (sc_wr),
        .wr_addr (cnt_q[AW-1:0]),
        .wr_data (sc_data),
        .rd_addr (cnt_q[AW-1:0]),
        .rd_data (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        err_d      = 1'b0;
        sc_ready   = 1'b0;
        agg_ready  = 1'b0;
        gelu_ready = 1'b0;
        ap_valid   = 1'b0;
        ap_mode    = '0;
        ap_data    = '0;
        ap_psum    = '0;

        case (state_q)
            ST_IDLE: begin
                // rst_n qualifies the pass-through so outputs stay low while held in reset.
                gelu_ready = rst_n && !start;
                if (start) begin
                    if (k_in_range(cfg_k, MAX_K)) begin
                        k_d     = CW'(cfg_k);
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (gelu_valid && gelu_ready) begin
                    ap_valid = 1'b1;
                    ap_mode  = MODE_GELU;
                    ap_data  = gelu_data;
                end
            end

            ST_LOAD: begin
                sc_ready = 1'b1;
                if (sc_valid) begin
                    if (last_op) begin
                        cnt_d   = '0;
                        state_d = ST_EXP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_EXP: begin
                ap_valid = 1'b1;
                ap_mode  = MODE_EXP;
                ap_data  = buf_rdata;
                if (last_op) begin
                    cnt_d   = '0;
                    state_d = ST_EXP_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_EXP_DRAIN: begin
                if (drain_end) begin
                    cnt_d   = '0;
                    state_d = ST_NORM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_NORM: begin
                ap_valid = 1'b1;
                ap_mode  = MODE_DIV;
                ap_data  = buf_rdata;
                if (last_op) begin
                    cnt_d   = '0;
                    state_d = ST_NORM_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_NORM_DRAIN: begin
                if (drain_end) begin
                    cnt_d   = '0;
                    state_d = ST_AGG;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_AGG: begin
                agg_ready = 1'b1;
                if (agg_valid) begin
                    ap_valid = 1'b1;
                    ap_mode  = MODE_AGG;
                    ap_data  = agg_data;
                    ap_psum  = agg_psum;
                    if (last_op) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed + randomized bench for arith_seq_ctrl; expected op streams are
// built from the token-level sequencing rules (scores in order, drains, pass-through).
module tb_arith_seq_ctrl;

    localparam int MAX_K     = 8;
    localparam int DRAIN_CYC = 4;
    localparam logic [1:0] M_EXP  = 2'd0;
    localparam logic [1:0] M_DIV  = 2'd1;
    localparam logic [1:0] M_GELU = 2'd2;
    localparam logic [1:0] M_AGG  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cfg_k = 4'd0;
    logic        sc_valid = 1'b0;
    logic        sc_ready;
    logic [15:0] sc_data = 16'd0;
    logic        agg_valid = 1'b0;
    logic        agg_ready;
    logic [15:0] agg_data = 16'd0;
    logic [15:0] agg_psum = 16'd0;
    logic        gelu_valid = 1'b0;
    logic        gelu_ready;
    logic [15:0] gelu_data = 16'd0;
    logic        ap_valid;
    logic [1:0]  ap_mode;
    logic [15:0] ap_data;
    logic [15:0] ap_psum;
    logic        busy;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;

    arith_seq_ctrl #(
        .MAX_K     (MAX_K),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_k      (cfg_k),
        .sc_valid   (sc_valid),
        .sc_ready   (sc_ready),
        .sc_data    (sc_data),
        .agg_valid  (agg_valid),
        .agg_ready  (agg_ready),
        .agg_data   (agg_data),
        .agg_psum   (agg_psum),
        .gelu_valid (gelu_valid),
        .gelu_ready (gelu_ready),
        .gelu_data  (gelu_data),
        .ap_valid   (ap_valid),
        .ap_mode    (ap_mode),
        .ap_data    (ap_data),
        .ap_psum    (ap_psum),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // No op issued and no handshake offered.
    task automatic chk_quiet(input string tag);
        chk({tag, "_ap_valid"}, ap_valid, 0);
        chk({tag, "_ap_mode"}, ap_mode, 0);
        chk({tag, "_ap_data"}, ap_data, 0);
        chk({tag, "_ap_psum"}, ap_psum, 0);
        chk({tag, "_sc_ready"}, sc_ready, 0);
        chk({tag, "_agg_ready"}, agg_ready, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic reject(input logic [3:0] k);
        @(negedge clk);
        start = 1'b1; cfg_k = k;
        #1;
        chk("rej_busy_same", busy, 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("rej_err_clear", err, 0);
        chk("rej_busy_after", busy, 0);
    endtask

    task automatic gelu_alone();
        logic [15:0] g;
        g = 16'($urandom);
        @(negedge clk);
        gelu_valid = 1'b1; gelu_data = g;
        #1;
        chk("gelu_ready", gelu_ready, 1);
        chk("gelu_valid", ap_valid, 1);
        chk("gelu_mode", ap_mode, M_GELU);
        chk("gelu_data", ap_data, g);
        chk("gelu_psum", ap_psum, 0);
        chk("gelu_busy", busy, 0);
        @(negedge clk);
        gelu_valid = 1'b0;
        #1;
        chk("gelu_off_valid", ap_valid, 0);
        chk("gelu_off_data", ap_data, 0);
    endtask

    // agg_gap < 0 selects a random 0..2 cycle gap before each aggregate beat.
    task automatic run_seq(input int k, input int max_gap, input int agg_gap, input bit req31,
                           input bit collide, input bit poke, input bit rst_norm);
        logic [15:0] sc [MAX_K];
        logic [15:0] ad, ap;
        int gap;
        @(negedge clk);
        start = 1'b1; cfg_k = 4'(k);
        if (collide) begin
            gelu_valid = 1'b1; gelu_data = 16'h1234;
        end
        #1;
        chk("start_busy", busy, 0);
        if (collide) begin
            chk("collide_gelu_ready", gelu_ready, 0);
            chk("collide_ap_valid", ap_valid, 0);
        end
        @(negedge clk);
        start = 1'b0; gelu_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                sc_valid = 1'b0;
                #1;
                chk("load_stall_ready", sc_ready, 1);
                chk("load_stall_busy", busy, 1);
                @(negedge clk);
            end
            sc[i] = req31 ? ((i == 0) ? 16'h3C00 : 16'h4000) : 16'($urandom);
            sc_valid = 1'b1; sc_data = sc[i];
            #1;
            chk("load_ready", sc_ready, 1);
            chk("load_ap_valid", ap_valid, 0);
            @(negedge clk);
        end
        sc_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (poke && i < 2) begin
                start = 1'b1; cfg_k = (i == 0) ? 4'd1 : 4'd0;
            end
            #1;
            chk("exp_valid", ap_valid, 1);
            chk("exp_mode", ap_mode, M_EXP);
            chk("exp_data", ap_data, sc[i]);
            chk("exp_psum", ap_psum, 0);
            chk("exp_sc_ready", sc_ready, 0);
            chk("exp_err", err, 0);
            @(negedge clk);
            start = 1'b0;
        end
        for (int d = 0; d < DRAIN_CYC; d++) begin
            #1;
            chk_quiet("exp_drain");
            chk("exp_drain_busy", busy, 1);
            chk("exp_drain_gelu_ready", gelu_ready, 0);
            chk("exp_drain_err", err, 0);
            @(negedge clk);
        end
        for (int i = 0; i < k; i++) begin
            #1;
            chk("norm_valid", ap_valid, 1);
            chk("norm_mode", ap_mode, M_DIV);
            chk("norm_data", ap_data, sc[i]);
            chk("norm_psum", ap_psum, 0);
            if (rst_norm) begin
                rst_n = 1'b0;
                #1;
                chk_quiet("rst_norm");
                chk("rst_norm_busy", busy, 0);
                chk("rst_norm_gelu_ready", gelu_ready, 0);
                chk("rst_norm_err", err, 0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    #1;
                    chk("post_rst_done", done, 0);
                    chk("post_rst_busy", busy, 0);
                    chk("post_rst_err", err, 0);
                end
                return;
            end
            @(negedge clk);
        end
        for (int d = 0; d < DRAIN_CYC; d++) begin
            #1;
            chk_quiet("norm_drain");
            chk("norm_drain_busy", busy, 1);
            @(negedge clk);
        end
        for (int j = 0; j < k; j++) begin
            gap = (agg_gap < 0) ? $urandom_range(0, 2) : agg_gap;
            for (int g = 0; g < gap; g++) begin
                agg_valid = 1'b0;
                #1;
                chk("agg_stall_valid", ap_valid, 0);
                chk("agg_stall_ready", agg_ready, 1);
                chk("agg_stall_done", done, 0);
                @(negedge clk);
            end
            ad = 16'($urandom); ap = 16'($urandom);
            agg_valid = 1'b1; agg_data = ad; agg_psum = ap;
            #1;
            chk("agg_valid", ap_valid, 1);
            chk("agg_mode", ap_mode, M_AGG);
            chk("agg_data", ap_data, ad);
            chk("agg_psum", ap_psum, ap);
            chk("agg_done", done, 0);
            @(negedge clk);
        end
        agg_valid = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_agg_ready", agg_ready, 0);
        chk("done_ap_valid", ap_valid, 0);
        @(negedge clk);
        #1;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        chk("reset_gelu_ready", gelu_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_gelu_ready", gelu_ready, 1);

        reject(4'd0);
        reject(4'd9);
        reject(4'd15);
        repeat (3) gelu_alone();

        run_seq(2, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_seq(3, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_seq(4, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_seq(5, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_seq(1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq(MAX_K, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 8; r++) begin
            run_seq($urandom_range(1, MAX_K), 2, -1, 1'b0, 1'b0, (r % 3) == 0, 1'b0);
            gelu_alone();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arith_seq_ctrl.md
ARITH_SEQ_CTRL -- requirements
Module: arith_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_K, default 8, maximum top-k experts per token.
REQ-002 SHALL have parameter DRAIN_CYC, default 4, cycles the arithmetic pipeline needs to retire its last issued op.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin one token sequence; cfg_k sampled same cycle.
REQ-006 cfg_k  input  4  number of experts for this token.
REQ-007 sc_valid / sc_ready / sc_data  in / out / in  1/1/16  gating-score stream, FP16.
REQ-008 agg_valid / agg_ready / agg_data / agg_psum  in / out / in / in  1/1/16/16  expert output and running psum, FP16.
REQ-009 gelu_valid / gelu_ready / gelu_data  in / out / in  1/1/16  standalone GeLU requests.
REQ-010 ap_valid / ap_mode / ap_data / ap_psum  out  1/2/16/16  drive to arithmetic pipeline; mode 0 exp+sum, 1 div, 2 GeLU, 3 AGG.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at end of sequence.
REQ-013 err  output  1  one-cycle pulse on rejected start.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, EXP, EXP_DRAIN, NORM, NORM_DRAIN, AGG, DONE.
REQ-015 IDLE: start with 1<=cfg_k<=MAX_K latches k and enters LOAD next cycle; other cfg_k pulses err, stays IDLE.
REQ-016 LOAD: sc_ready=1; each sc_valid&&sc_ready writes sc_data to score buffer[idx], idx++; after k-th accept -> EXP.
REQ-017 EXP: issue one op per cycle, ap_valid=1, ap_mode=0, ap_data=buffer[i], i=0..k-1; after k ops -> EXP_DRAIN.
REQ-018 EXP_DRAIN/NORM_DRAIN: ap_valid=0 for exactly DRAIN_CYC cycles, then -> NORM / AGG respectively.
REQ-019 NORM: k ops, ap_mode=1, ap_data=buffer[i], one per cycle, no gaps.
REQ-020 AGG: agg_ready=1; each accepted beat drives ap_valid=1, ap_mode=3, ap_data=agg_data, ap_psum=agg_psum same cycle (combinational pass-through); after k-th beat -> DONE.
REQ-021 DONE: done=1 for one cycle, -> IDLE.
REQ-022 GeLU: gelu_ready=1 only in IDLE with start low; accepted beat drives ap_valid=1, ap_mode=2, ap_data=gelu_data same cycle; start has priority over gelu_valid in the same cycle.
REQ-023 ap_psum SHALL be 0 in every mode except 3; ap_data/ap_mode SHALL be 0 when ap_valid=0.
REQ-024 start while busy SHALL be ignored (no err, no restart).
REQ-025 sc_ready/agg_ready SHALL be 0 outside LOAD/AGG; stalls (valid low) in LOAD/AGG hold state indefinitely.
REQ-026 Counters SHALL be width clog2(MAX_K)+1 and reset to 0 on each state entry; no wrap within a sequence.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, counters=0, k=0, all outputs 0; score buffer contents undefined and not cleared.
REQ-028 Reset mid-sequence SHALL abandon the sequence without done or err pulses.

Structure
REQ-029 Shared package SHALL hold mode encodings (MODE_EXP=0, MODE_DIV=1, MODE_GELU=2, MODE_AGG=3), FSM state enum and FP16 width constant.
REQ-030 Score buffer SHALL be one sub-module, seq_score_buf (MAX_K x 16, 1 write, 1 async read); FSM and muxing inline.

Verification
REQ-031 k=2, scores 0x3C00,0x4000 -> EXP ops ap_data 0x3C00,0x4000 mode 0 on consecutive cycles, 4 idle cycles, NORM ops same data mode 1, then AGG.
REQ-032 k=3 AGG beats with gaps of 2 cycles -> 3 mode-3 ops mirroring agg_data/agg_psum, done pulses exactly once one cycle after 3rd beat.
REQ-033 start with cfg_k=0 and cfg_k=9 -> err pulse each, busy stays 0.
REQ-034 start and gelu_valid same cycle in IDLE -> gelu_ready=0, sequence starts; gelu in IDLE alone -> ap_mode=2 same cycle.
REQ-035 rst_n asserted during NORM -> outputs 0 immediately, IDLE, no done; new start k=1 completes normally.
REQ-036 start pulsed during EXP -> ignored, op count and data unchanged.
